// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the IF/MEM byte-wide memory controller:
// transfer lengths, FSM states, requester ids and small byte helpers.
package mem_ctrl_pkg;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    REQ_IF  = 1'b0,
    REQ_MEM = 1'b1
  } req_id_t;

  // Byte count for a length code; the unused code 2 behaves as a word.
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

  // Little-endian byte lane select.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates one 8-bit synchronous RAM port between instruction fetch and
// memory access (MEM wins), then moves 1/2/4 bytes one per cycle.
// Reads are assembled little-endian; every output is a register.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  state_t            state_reg;
  req_id_t           req_id_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [2:0]        n_reg;       // bytes in this transfer
  logic [2:0]        k_reg;       // XFER cycle index: byte k issued, byte k-1 captured
  logic              we_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       result_reg;
  logic [31:0]       result_next;
  logic [2:0]        k_next;
  logic              xfer_end;
  logic              if_flushed;

  assign k_next     = k_reg + 3'd1;
  // Writes end on the last issue; reads need one more cycle to capture.
  assign xfer_end   = we_reg ? (k_next == n_reg) : (k_reg == n_reg);
  assign if_flushed = (req_id_reg == REQ_IF) && if_flush;

  // Merge the byte returning from the previous cycle's address into the result.
  always_comb begin
    result_next = result_reg;
    if (!we_reg) begin
      for (int b = 0; b < 4; b++) begin
        if (k_reg == 3'(b + 1)) result_next[8*b +: 8] = ram_din;
      end
    end
  end

  // Arbitration FSM, byte sequencing and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      req_id_reg <= REQ_IF;
      base_reg   <= '0;
      n_reg      <= 3'd0;
      k_reg      <= 3'd0;
      we_reg     <= 1'b0;
      wdata_reg  <= '0;
      result_reg <= '0;
      if_done    <= 1'b0;
      mem_done   <= 1'b0;
      if_data    <= '0;
      mem_rdata  <= '0;
      ram_addr   <= '0;
      ram_wr     <= 1'b0;
      ram_dout   <= '0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          ram_wr <= 1'b0;
          if (mem_req) begin
            // Grant issues byte 0 on the same edge.
            state_reg  <= ST_XFER;
            req_id_reg <= REQ_MEM;
            base_reg   <= mem_addr;
            n_reg      <= len_to_bytes(mem_len);
            we_reg     <= mem_we;
            wdata_reg  <= mem_wdata;
            k_reg      <= 3'd0;
            result_reg <= '0;
            ram_addr   <= mem_addr;
            ram_wr     <= mem_we;
            if (mem_we) ram_dout <= mem_wdata[7:0];
          end else if (if_req && !if_flush) begin
            state_reg  <= ST_XFER;
            req_id_reg <= REQ_IF;
            base_reg   <= if_addr;
            n_reg      <= 3'd4;
            we_reg     <= 1'b0;
            wdata_reg  <= '0;
            k_reg      <= 3'd0;
            result_reg <= '0;
            ram_addr   <= if_addr;
          end
        end
        ST_XFER: begin
          if (if_flushed) begin
            state_reg <= ST_IDLE;
            ram_wr    <= 1'b0;
          end else begin
            k_reg      <= k_next;
            result_reg <= result_next;
            if (k_next < n_reg) begin
              ram_addr <= base_reg + ADDR_W'(k_next);
              ram_wr   <= we_reg;
              if (we_reg) ram_dout <= byte_sel(wdata_reg, k_next[1:0]);
            end else begin
              ram_wr <= 1'b0;
            end
            if (xfer_end) begin
              state_reg <= ST_DONE;
              if (req_id_reg == REQ_MEM) begin
                mem_done <= 1'b1;
                if (!we_reg) mem_rdata <= result_next;
              end else begin
                if_done <= 1'b1;
                if_data <= result_next;
              end
            end
          end
        end
        default: begin
          // DONE: the pulse clears by default; no requests are sampled here.
          state_reg <= ST_IDLE;
          ram_wr    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed table, hand-written corner
// sequences and randomized transfers against a byte-array reference model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_data;
  logic        mem_req, mem_we, mem_done;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout, ram_din;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  // Synchronous RAM (64 KiB window, low address bits) with a preload port.
  logic [7:0]  ram    [0:65535];
  logic [7:0]  shadow [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  int          wr_cnt = 0;

  always @(posedge clk) begin
    if (ram_wr) begin
      ram[ram_addr[15:0]] <= ram_dout;
      wr_cnt <= wr_cnt + 1;
    end else if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end
    ram_din <= ram[ram_addr[15:0]];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    shadow[a] = d;
  endtask

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  // One isolated transfer: checks latency, read data and RAM write count.
  task automatic do_xfer(input string nm, input bit is_if, input bit we, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input int exp_lat);
    int lat = 0;
    int wr0;
    logic [31:0] got = '0;
    @(negedge clk);
    wr0 = wr_cnt;
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata;
    end
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (is_if ? if_done : mem_done) begin
        lat = j;
        got = is_if ? if_data : mem_rdata;
        break;
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    $display("[TB] %s %s we=%0d len=%0d addr=0x%08h data=0x%08h lat=%0d",
             nm, is_if ? "IF" : "MEM", we, len, addr, got, lat);
    check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    if (!we) check({nm, "_data"}, got, exp_data);
    check({nm, "_wrcnt"}, 32'(wr_cnt - wr0), we ? 32'(nbytes(len)) : 32'd0);
  endtask

  typedef struct {
    string       nm;
    bit          is_if;
    bit          we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int mem_j, if_j;
    bit if_seen;
    logic [31:0] got;
    logic [31:0] wrap_seq [4];

    rst = 1'b1; if_req = 0; if_addr = 0; if_flush = 0;
    mem_req = 0; mem_we = 0; mem_len = 0; mem_addr = 0; mem_wdata = 0;

    // Preload while held in reset.
    preload(16'h0100, 8'h13); preload(16'h0101, 8'h05);
    preload(16'h0102, 8'h10); preload(16'h0103, 8'h00);
    preload(16'h0020, 8'hFF);
    preload(16'h0040, 8'h11); preload(16'h0041, 8'h00);
    preload(16'h0042, 8'h00); preload(16'h0043, 8'h44);
    preload(16'hFFFE, 8'hA1); preload(16'hFFFF, 8'hB2);
    preload(16'h0000, 8'hC3); preload(16'h0001, 8'hD4);
    preload(16'h0303, 8'h5A);
    for (int a = 16'h0400; a < 16'h0500; a++) preload(16'(a), 8'($urandom));
    @(negedge clk);
    pl_en = 1'b0;

    check("rst_if_done",   {31'd0, if_done},  32'd0);
    check("rst_mem_done",  {31'd0, mem_done}, 32'd0);
    check("rst_if_data",   if_data,   32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_ram_addr",  ram_addr,  32'd0);
    check("rst_ram_wr",    {31'd0, ram_wr}, 32'd0);
    check("rst_ram_dout",  {24'd0, ram_dout}, 32'd0);
    rst = 1'b0;

    // Word fetch with address stepping.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    if_j = 0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j <= 4) check("fetch_addr", ram_addr, 32'h100 + 32'(j - 1));
      if (if_done && if_j == 0) begin if_j = j; got = if_data; if_req = 1'b0; end
    end
    if_req = 1'b0;
    $display("[TB] fetch lat=%0d data=0x%08h", if_j, got);
    check("fetch_lat", 32'(if_j), 32'd6);
    check("fetch_data", got, 32'h00100513);

    // Directed table.
    vecs[0] = '{"tbl_fetch",   1, 0, 2'd3, 32'h100, 32'h0,        32'h00100513, 6};
    vecs[1] = '{"tbl_rd_b",    0, 0, 2'd0, 32'h20,  32'h0,        32'h000000FF, 3};
    vecs[2] = '{"tbl_wr_h",    0, 1, 2'd1, 32'h41,  32'hAABBCCDD, 32'h0,        3};
    vecs[3] = '{"tbl_rd_h",    0, 0, 2'd1, 32'h41,  32'h0,        32'h0000CCDD, 4};
    vecs[4] = '{"tbl_rd_w",    0, 0, 2'd3, 32'h40,  32'h0,        32'h44CCDD11, 6};
    vecs[5] = '{"tbl_rd_len2", 0, 0, 2'd2, 32'h40,  32'h0,        32'h44CCDD11, 6};
    vecs[6] = '{"tbl_wr_b",    0, 1, 2'd0, 32'h50,  32'h12345678, 32'h0,        2};
    vecs[7] = '{"tbl_rd_b2",   0, 0, 2'd0, 32'h50,  32'h0,        32'h00000078, 3};
    for (int i = 0; i < 8; i++)
      do_xfer(vecs[i].nm, vecs[i].is_if, vecs[i].we, vecs[i].len, vecs[i].addr,
              vecs[i].wdata, vecs[i].exp_data, vecs[i].exp_lat);
    check("hw_byte41", {24'd0, ram[16'h41]}, 32'hDD);
    check("hw_byte42", {24'd0, ram[16'h42]}, 32'hCC);
    check("hw_byte43", {24'd0, ram[16'h43]}, 32'h44);

    // Collision: MEM wins, IF follows 7 cycles later.
    @(negedge clk);
    mem_req = 1'b1; mem_we = 0; mem_len = 2'd0; mem_addr = 32'h20;
    if_req = 1'b1; if_addr = 32'h100;
    mem_j = 0; if_j = 0; got = '0;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (mem_done && mem_j == 0) begin mem_j = j; got = mem_rdata; mem_req = 1'b0; end
      if (if_done && if_j == 0) begin if_j = j; if_req = 1'b0; end
    end
    mem_req = 1'b0; if_req = 1'b0;
    $display("[TB] collision mem_lat=%0d if_lat=%0d mem_rdata=0x%08h", mem_j, if_j, got);
    check("coll_mem_lat", 32'(mem_j), 32'd3);
    check("coll_mem_data", got, 32'h000000FF);
    check("coll_if_lat", 32'(if_j), 32'd10);

    // Flush during third byte of an IF read, MEM waiting.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    if_seen = 0; mem_j = 0;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (j == 3) begin
        check("flush_byte2_addr", ram_addr, 32'h102);
        if_flush = 1'b1; if_req = 1'b0;
        mem_req = 1'b1; mem_we = 0; mem_len = 2'd0; mem_addr = 32'h20;
      end
      if (j == 4) if_flush = 1'b0;
      if (j == 5) check("flush_mem_issue", ram_addr, 32'h20);
      if (if_done) if_seen = 1;
      if (mem_done && mem_j == 0) begin mem_j = j; mem_req = 1'b0; end
    end
    mem_req = 1'b0;
    $display("[TB] flush if_done_seen=%0d mem_lat=%0d", if_seen, mem_j);
    check("flush_no_if_done", {31'd0, if_seen}, 32'd0);
    check("flush_mem_lat", 32'(mem_j), 32'd7);

    // Address wrap.
    wrap_seq[0] = 32'hFFFFFFFE; wrap_seq[1] = 32'hFFFFFFFF;
    wrap_seq[2] = 32'h0;        wrap_seq[3] = 32'h1;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 0; mem_len = 2'd3; mem_addr = 32'hFFFFFFFE;
    mem_j = 0; got = '0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j <= 4) check("wrap_addr", ram_addr, wrap_seq[j-1]);
      if (mem_done && mem_j == 0) begin mem_j = j; got = mem_rdata; mem_req = 1'b0; end
    end
    mem_req = 1'b0;
    $display("[TB] wrap lat=%0d data=0x%08h", mem_j, got);
    check("wrap_lat", 32'(mem_j), 32'd6);
    check("wrap_data", got, 32'hD4C3B2A1);

    // Reset during byte 2 of a word write.
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1; mem_len = 2'd3; mem_addr = 32'h300; mem_wdata = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    check("rstw_wr_before", {31'd0, ram_wr}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstw_ram_wr",    {31'd0, ram_wr},   32'd0);
    check("rstw_mem_done",  {31'd0, mem_done}, 32'd0);
    check("rstw_if_done",   {31'd0, if_done},  32'd0);
    check("rstw_if_data",   if_data,   32'd0);
    check("rstw_mem_rdata", mem_rdata, 32'd0);
    check("rstw_ram_addr",  ram_addr,  32'd0);
    check("rstw_ram_dout",  {24'd0, ram_dout}, 32'd0);
    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    mem_j = 0;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (mem_done || ram_wr) mem_j = j;
    end
    $display("[TB] reset mid-write, activity after reset at %0d", mem_j);
    check("rstw_quiet", 32'(mem_j), 32'd0);
    check("rstw_b0", {24'd0, ram[16'h300]}, 32'h0D);
    check("rstw_b3", {24'd0, ram[16'h303]}, 32'h5A);

    // Randomized transfers against the byte-array reference model.
    for (int i = 0; i < 40; i++) begin
      bit          r_if;
      bit          r_we;
      logic [1:0]  r_len;
      logic [31:0] r_addr, r_wdata, r_exp;
      int          n;
      r_if    = ($urandom_range(0, 3) == 0);
      r_len   = r_if ? 2'd3 : 2'($urandom_range(0, 3));
      r_we    = r_if ? 1'b0 : 1'($urandom_range(0, 1));
      r_addr  = 32'h400 + 32'($urandom_range(0, 16'hF0));
      r_wdata = $urandom;
      n       = nbytes(r_len);
      r_exp   = '0;
      for (int b = 0; b < n; b++) begin
        if (r_we) shadow[16'(r_addr + 32'(b))] = r_wdata[8*b +: 8];
        else      r_exp = r_exp | (32'(shadow[16'(r_addr + 32'(b))]) << (8 * b));
      end
      do_xfer("rand", r_if, r_we, r_len, r_addr, r_wdata, r_exp, r_we ? n + 1 : n + 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-wide memory controller and arbiter between the instruction-fetch (IF) and memory-access (MEM) stages of the RISC-V core inside `openmips_min_sopc`. Both stages share a single 8-bit synchronous RAM port. This block grants that port to one requester at a time, with MEM having priority. It then sequences the multi-byte transfer byte by byte, assembling reads little-endian and slicing writes. Each completed transfer is reported to its requester with a single-cycle done pulse.

## Interface
Parameters:
- ADDR_W, 32, address width of requesters and RAM port.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset (`RstEnable` = 1).
- if_req  in  1  IF read request; held with if_addr until if_done or if_flush.
- if_addr  in  ADDR_W  IF byte address; always a 4-byte read.
- if_flush  in  1  cancel any pending or in-flight IF read.
- if_done  out  1  one-cycle pulse: if_data valid.
- if_data  out  32  fetched instruction word.
- mem_req  in  1  MEM request; held with other mem_* inputs until mem_done.
- mem_we  in  1  1 = write, 0 = read.
- mem_len  in  2  0 = 1 byte, 1 = 2 bytes, 3 = 4 bytes; 2 is illegal and treated as 4.
- mem_addr  in  ADDR_W  MEM byte address.
- mem_wdata  in  32  write data; byte k = mem_wdata[8k+7:8k].
- mem_done  out  1  one-cycle pulse: transfer complete, mem_rdata valid for reads.
- mem_rdata  out  32  read data, zero-extended; the MEM stage performs sign extension.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_wr  out  1  RAM write enable.
- ram_dout  out  8  RAM write data.
- ram_din  in  8  RAM read data for the address presented in the previous cycle.

## Operation
- FSM states: IDLE, XFER, DONE.
- **IDLE:**
  - Samples requests. If mem_req is high, grant MEM; otherwise, if if_req is high and if_flush is low, grant IF. MEM has fixed priority.
  - On grant, latch the requester, base address, N (byte count: 1, 2 or 4), the we flag and wdata. Clear byte counter k and go to XFER.
- **XFER** (byte counter k):
  - Issue: ram_addr = base + k, with modulo 2^ADDR_W wrap. For writes, ram_wr = 1 and ram_dout = wdata byte k.
  - Capture (reads only): ram_din is stored into result byte k−1 for k ≥ 1, plus a final capture cycle after the last issue.
  - Exit: go to DONE after the last write byte is issued, or after the last read byte is captured.
- **DONE:** pulse the granted requester's done output, drive the assembled data, then return to IDLE. Requests are not sampled in DONE.
- **Read result:** bytes not transferred (k ≥ N) read as 0.
- **if_flush:**
  - In IDLE: blocks an IF grant.
  - During an IF read in XFER/DONE: abort to IDLE on the next edge; if_done is never pulsed for the flushed read.
  - Has no effect on a MEM transfer.
- **Idle outputs:** when not issuing, ram_wr = 0 and ram_addr holds its last value.
- **Reset:** synchronous, mid-transfer included. Next state is IDLE; all outputs return to reset values; any partial write is left as is.
- **Reset values:** if_done = 0, mem_done = 0, if_data = 0, mem_rdata = 0, ram_addr = 0, ram_wr = 0, ram_dout = 0.
- **Requester rule:** each requester deasserts req in the cycle after its done pulse.

## Timing
- **Read latency:** request sampled in IDLE at cycle t. Byte addresses are presented in cycles t+1..t+N; data returns in t+2..t+N+1; done pulses in cycle t+N+2. A 4-byte fetch therefore completes 6 cycles after it is sampled.
- **Write latency:** bytes written in cycles t+1..t+N; done pulses in cycle t+N+1.
- **Back-to-back transfers:** the earliest next grant is the IDLE cycle immediately after DONE, so a 4-byte IF read repeats every 7 cycles.
- **No preemption:** a MEM request arriving during an IF transfer waits for that transfer's DONE, then wins the following IDLE.
- **Simultaneous requests:** if mem_req and if_req are both high in IDLE, MEM is granted; IF is granted in the IDLE after MEM's DONE.
- **All outputs are registered.** No combinational path runs from any input to any output.

## Structure
- **In `defines.v`** (shared with the pipeline):
  - Length encodings: LenByte = 2'd0, LenHalf = 2'd1, LenWord = 2'd3.
  - FSM state encodings.
  - Requester ids.
- **Module structure:** a single module. The FSM, byte counter and shift/assembly logic are tightly coupled, so no sub-module is warranted.

## Test plan
- **Word fetch:** reset, then if_req with if_addr = 0x100 while RAM holds 0x13 0x05 0x10 0x00 at 0x100..0x103 -> ram_addr steps 0x100..0x103; if_done pulses exactly 6 cycles after the request is sampled, with if_data = 0x00100513.
- **Collision:** mem_req (read, len 1, addr 0x20, RAM = 0xFF) and if_req asserted in the same cycle -> mem_done fires first with mem_rdata = 0x000000FF; if_done follows 7 cycles later.
- **Half-word write:** mem_we = 1, len 1, mem_addr = 0x41, mem_wdata = 0xAABBCCDD -> ram_wr is high for exactly 2 cycles, writing 0xDD to 0x41 and 0xCC to 0x42; mem_done pulses in cycle t+3.
- **Flush:** if_flush asserted during the third byte of an IF read -> no if_done; the FSM is in IDLE on the next cycle; an immediately pending mem_req is granted in that IDLE.
- **Address wrap:** word read at mem_addr = 0xFFFFFFFE -> ram_addr sequence is 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- **Reset mid-write:** rst asserted during byte 2 of a word write -> the next cycle has ram_wr = 0, no done pulse, and all outputs at reset values.
